mem_store_buffer: RTL and testbench
===================================

// Module: mem_store_buffer
// PURPOSE
//  Word-store write buffer between the MEM-stage store path and the data memory write port.
//  Buffers up to DEPTH committed word stores in FIFO order and drains one per cycle into
//  the data memory (WE/Addr/WD/PCnow).
//  Forwards the youngest buffered data to same-cycle loads, so the MEM stage reads coherent
//  data before the write has drained.
//  Back-pressures the pipeline through st_ready when full.
// PARAMETERS
//  DEPTH  4   entries; power of 2, >=2; PTR_W = $clog2(DEPTH)
//  AW     32  address width (byte address)
//  DW     32  data width (one word)
// PORTS
//  clk          in   1         single clock, all state on posedge
//  reset        in   1         synchronous, active-high; empties buffer
//  st_valid     in   1         MEM stage presents a store this cycle
//  st_ready     out  1         buffer accepts store; push = st_valid & st_ready
//  st_addr      in   AW        store byte address (word aligned; [1:0] ignored)
//  st_wd        in   DW        store data
//  st_pc        in   32        PC of store instruction, carried for memory write trace
//  ld_valid     in   1         MEM stage performs a load this cycle
//  ld_addr      in   AW        load byte address
//  ld_hit       out  1         comb: buffered entry matches ld_addr word; use ld_data
//  ld_data      out  DW        comb: data of youngest matching entry (0 when !ld_hit)
//  dm_ready     in   1         data memory write port free this cycle
//  dm_we        out  1         comb: write head entry this cycle = !empty & dm_ready
//  dm_addr      out  AW        head entry address
//  dm_wd        out  DW        head entry data
//  dm_pc        out  32        head entry PC
//  empty        out  1         no entries buffered
//  count        out  PTR_W+1   number of valid entries, 0..DEPTH
// BEHAVIOUR
//  - Storage: circular array of {addr,wd,pc}; head/tail pointers PTR_W bits, wrap modulo
//    DEPTH; count tracked separately so full (count==DEPTH) and empty (count==0) are distinct.
//  - Reset (sync): head=tail=0, count=0. Gives empty=1, st_ready=1, dm_we=0, ld_hit=0,
//    ld_data=0. Entry contents are don't-care.
//    Reset mid-drain or with pending stores discards all entries; no dm_we in the reset cycle
//    or the cycle after.
//  - st_ready = (count != DEPTH). Registered-state only; no combinational path from dm_ready.
//    A full buffer rejects a push even when a drain fires in the same cycle.
//  - Push: entry[tail] <= {st_addr,st_wd,st_pc}; tail++. Latency push->earliest dm_we = 1 cycle.
//  - Drain fire = dm_we (= !empty & dm_ready): head++. The memory captures the write on the
//    same edge.
//  - count' = count + push - fire. Push and fire in the same cycle leave count unchanged.
//    Push into a 1-entry buffer while it drains is legal.
//  - Order: entries drain strictly oldest-first; dm_* are driven from entry[head] whenever
//    !empty.
//    dm_addr/dm_wd/dm_pc are don't-care when empty, but are held at the last head value
//    (no X).
//  - Forwarding: compare ld_addr[AW-1:2] with addr[AW-1:2] of every valid entry. On multiple
//    matches, the entry youngest in program order (closest to tail) wins.
//    ld_hit is gated by ld_valid.
//  - The head entry draining this cycle still forwards, because memory holds the old value
//    until the edge.
//  - A store pushed in the same cycle is not visible to the same-cycle load (single-issue
//    guarantees no same-cycle store and load from one instruction).
// CONFIGURATION
//  SB_COALESCE_EN defined: a push whose word address equals the youngest valid entry
//    (tail-1) overwrites that entry's wd and pc instead of allocating.
//    Pointers and count are unchanged.
//    - Coalescing is allowed when the buffer is full: st_ready = !full | coalesce_match.
//    - Coalescing is suppressed when that entry is the head and fires this cycle; the store
//      then allocates normally.
//  SB_COALESCE_EN undefined: every accepted push allocates a new entry; st_ready = !full.
// TESTING
//  1 reset, then push 0x10<=0xAAAA0001 with dm_ready=1 -> next cycle dm_we=1, dm_addr=0x10,
//    dm_wd=0xAAAA0001; following cycle empty=1.
//  2 dm_ready=0, push 4 stores to 0x0,0x4,0x8,0xC -> count=4, st_ready=0; a 5th push is
//    ignored. Then dm_ready=1 -> 4 writes drain in order 0x0..0xC over 4 cycles.
//  3 dm_ready=0, push 0x20<=1 then 0x20<=2; ld 0x22 -> ld_hit=1, ld_data=2.
//    ld 0x24 -> ld_hit=0, ld_data=0.
//  4 one entry 0x30<=5 draining (dm_ready=1) while ld 0x30 -> ld_hit=1, ld_data=5 in the
//    fire cycle; next cycle ld_hit=0.
//  5 3 entries buffered, reset=1 for one cycle -> count=0, empty=1, dm_we=0; none of the
//    discarded writes ever appear.
//  6 SB_COALESCE_EN, dm_ready=0: push 0x40<=7 then 0x40<=9 -> count=1; drain gives one write,
//    0x40<=9. Without the macro -> count=2, two writes.

Source files
------------

// File: rtl/mem_store_buffer.sv
// mem_store_buffer: FIFO word-store write buffer between the MEM-stage store path
// and the data memory write port. Drains one entry per cycle, oldest first, and
// forwards the youngest matching buffered word to same-cycle loads.
// Optional feature macro: SB_COALESCE_EN (a store to the youngest entry's word
// overwrites that entry instead of allocating a new one).
module mem_store_buffer #(
  parameter  int DEPTH = 4,
  parameter  int AW    = 32,
  parameter  int DW    = 32,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             st_valid_i,
  output logic             st_ready_o,
  input  logic [AW-1:0]    st_addr_i,
  input  logic [DW-1:0]    st_wd_i,
  input  logic [31:0]      st_pc_i,
  input  logic             ld_valid_i,
  input  logic [AW-1:0]    ld_addr_i,
  output logic             ld_hit_o,
  output logic [DW-1:0]    ld_data_o,
  input  logic             dm_ready_i,
  output logic             dm_we_o,
  output logic [AW-1:0]    dm_addr_o,
  output logic [DW-1:0]    dm_wd_o,
  output logic [31:0]      dm_pc_o,
  output logic             empty_o,
  output logic [PTR_W:0]   count_o
);

  // Word-address mask: byte-offset bits never take part in a match.
  localparam logic [AW-1:0] WMASK = ~AW'(3);

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    wd_q   [DEPTH];
  logic [31:0]      pc_q   [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic             full, empty, fire, push, alloc, coal;
  logic [PTR_W-1:0] young_idx, out_idx;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (PTR_W+1)'(DEPTH));
  assign young_idx = tail_q - PTR_W'(1);

  // Drain fires whenever there is a head entry and the memory port is free;
  // suppressed during reset so no discarded write can leak out.
  assign fire    = !empty && dm_ready_i && !reset_i;
  assign dm_we_o = fire;

`ifdef SB_COALESCE_EN
  logic coal_match;
  // Youngest entry matches the store word and is not the lone head leaving this cycle.
  always_comb begin
    coal_match = !empty &&
                 ((addr_q[young_idx] & WMASK) == (st_addr_i & WMASK)) &&
                 !((count_q == (PTR_W+1)'(1)) && fire);
  end
  assign st_ready_o = !full || coal_match;
  assign push       = st_valid_i && st_ready_o;
  assign coal       = push && coal_match;
  assign alloc      = push && !coal_match;
`else
  assign st_ready_o = !full;
  assign push       = st_valid_i && st_ready_o;
  assign coal       = 1'b0;
  assign alloc      = push;
`endif

  // Pointer and occupancy next-state.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + (PTR_W+1)'(alloc) - (PTR_W+1)'(fire);
    if (fire)  head_d = head_q + PTR_W'(1);
    if (alloc) tail_d = tail_q + PTR_W'(1);
  end

  // Pointer/count registers and entry storage writes.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        wd_q[i]   <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (alloc) begin
        addr_q[tail_q] <= st_addr_i;
        wd_q[tail_q]   <= st_wd_i;
        pc_q[tail_q]   <= st_pc_i;
      end
      if (coal) begin
        wd_q[young_idx] <= st_wd_i;
        pc_q[young_idx] <= st_pc_i;
      end
    end
  end

  // When empty, point at the most recently drained slot so dm_* hold the last head value.
  assign out_idx   = empty ? (head_q - PTR_W'(1)) : head_q;
  assign dm_addr_o = addr_q[out_idx];
  assign dm_wd_o   = wd_q[out_idx];
  assign dm_pc_o   = pc_q[out_idx];
  assign empty_o   = empty;
  assign count_o   = count_q;

  // Forwarding: walk entries oldest to youngest so the youngest match wins.
  // The draining head is still valid here since memory updates only at the edge.
  always_comb begin
    logic [PTR_W-1:0] fidx;
    ld_hit_o  = 1'b0;
    ld_data_o = '0;
    fidx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fidx = head_q + PTR_W'(i);
      if ((i < int'(count_q)) && ((addr_q[fidx] & WMASK) == (ld_addr_i & WMASK))) begin
        ld_hit_o  = 1'b1;
        ld_data_o = wd_q[fidx];
      end
    end
    if (!ld_valid_i) begin
      ld_hit_o  = 1'b0;
      ld_data_o = '0;
    end
  end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Directed self-checking bench for mem_store_buffer (DEPTH=4, AW=DW=32).
module tb_mem_store_buffer;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        st_valid_i = 1'b0;
  logic        st_ready_o;
  logic [31:0] st_addr_i = '0;
  logic [31:0] st_wd_i = '0;
  logic [31:0] st_pc_i = '0;
  logic        ld_valid_i = 1'b0;
  logic [31:0] ld_addr_i = '0;
  logic        ld_hit_o;
  logic [31:0] ld_data_o;
  logic        dm_ready_i = 1'b0;
  logic        dm_we_o;
  logic [31:0] dm_addr_o;
  logic [31:0] dm_wd_o;
  logic [31:0] dm_pc_o;
  logic        empty_o;
  logic [2:0]  count_o;

  int n_cmp = 0;
  int n_err = 0;

  mem_store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .st_valid_i(st_valid_i), .st_ready_o(st_ready_o),
    .st_addr_i(st_addr_i), .st_wd_i(st_wd_i), .st_pc_i(st_pc_i),
    .ld_valid_i(ld_valid_i), .ld_addr_i(ld_addr_i),
    .ld_hit_o(ld_hit_o), .ld_data_o(ld_data_o),
    .dm_ready_i(dm_ready_i), .dm_we_o(dm_we_o),
    .dm_addr_o(dm_addr_o), .dm_wd_o(dm_wd_o), .dm_pc_o(dm_pc_o),
    .empty_o(empty_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock; inputs are driven 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; dm_ready_i = 1'b1; ld_valid_i = 1'b1; ld_addr_i = 32'h0;
    step(); step();
    reset_i = 1'b0;
    #1;
    n_cmp++; if (empty_o !== 1'b1) begin n_err++; $display("FAIL rst_empty got=%0b exp=1", empty_o); end
    n_cmp++; if (st_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_st_ready got=%0b exp=1", st_ready_o); end
    n_cmp++; if (dm_we_o !== 1'b0) begin n_err++; $display("FAIL rst_dm_we got=%0b exp=0", dm_we_o); end
    n_cmp++; if (ld_hit_o !== 1'b0 || ld_data_o !== 32'h0) begin n_err++; $display("FAIL rst_ld got=%0b/%h exp=0/0", ld_hit_o, ld_data_o); end
    n_cmp++; if (count_o !== 3'd0) begin n_err++; $display("FAIL rst_count got=%0d exp=0", count_o); end
    ld_valid_i = 1'b0; dm_ready_i = 1'b0;
  endtask

  task automatic test_single();
    dm_ready_i = 1'b1;
    st_valid_i = 1'b1; st_addr_i = 32'h10; st_wd_i = 32'hAAAA0001; st_pc_i = 32'h100;
    #1;
    n_cmp++; if (dm_we_o !== 1'b0) begin n_err++; $display("FAIL t1_we_before got=%0b exp=0", dm_we_o); end
    step();
    st_valid_i = 1'b0;
    #1;
    n_cmp++; if (dm_we_o !== 1'b1) begin n_err++; $display("FAIL t1_we got=%0b exp=1", dm_we_o); end
    n_cmp++; if (dm_addr_o !== 32'h10) begin n_err++; $display("FAIL t1_addr got=%h exp=00000010", dm_addr_o); end
    n_cmp++; if (dm_wd_o !== 32'hAAAA0001) begin n_err++; $display("FAIL t1_wd got=%h exp=aaaa0001", dm_wd_o); end
    n_cmp++; if (dm_pc_o !== 32'h100) begin n_err++; $display("FAIL t1_pc got=%h exp=00000100", dm_pc_o); end
    n_cmp++; if (count_o !== 3'd1) begin n_err++; $display("FAIL t1_count got=%0d exp=1", count_o); end
    step();
    n_cmp++; if (empty_o !== 1'b1 || dm_we_o !== 1'b0) begin n_err++; $display("FAIL t1_drained got=empty %0b we %0b exp=1/0", empty_o, dm_we_o); end
    dm_ready_i = 1'b0;
  endtask

  task automatic test_full();
    dm_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      st_valid_i = 1'b1; st_addr_i = 32'(4*i); st_wd_i = 32'hB000_0000 + 32'(i); st_pc_i = 32'h200 + 32'(4*i);
      step();
    end
    st_valid_i = 1'b0;
    #1;
    n_cmp++; if (count_o !== 3'd4) begin n_err++; $display("FAIL t2_count_full got=%0d exp=4", count_o); end
    n_cmp++; if (st_ready_o !== 1'b0) begin n_err++; $display("FAIL t2_st_ready got=%0b exp=0", st_ready_o); end
    // 5th push while full and draining: must be rejected.
    st_valid_i = 1'b1; st_addr_i = 32'h50; st_wd_i = 32'hDEAD0050; dm_ready_i = 1'b1;
    #1;
    n_cmp++; if (st_ready_o !== 1'b0) begin n_err++; $display("FAIL t2_ready_drain got=%0b exp=0", st_ready_o); end
    n_cmp++; if (dm_we_o !== 1'b1 || dm_addr_o !== 32'h0 || dm_wd_o !== 32'hB0000000) begin n_err++; $display("FAIL t2_drain0 got=%0b/%h/%h exp=1/00000000/b0000000", dm_we_o, dm_addr_o, dm_wd_o); end
    step();
    st_valid_i = 1'b0;
    #1;
    n_cmp++; if (count_o !== 3'd3) begin n_err++; $display("FAIL t2_count_after got=%0d exp=3", count_o); end
    for (int i = 1; i < 4; i++) begin
      n_cmp++;
      if (dm_we_o !== 1'b1 || dm_addr_o !== 32'(4*i) || dm_wd_o !== 32'hB000_0000 + 32'(i) || dm_pc_o !== 32'h200 + 32'(4*i)) begin
        n_err++; $display("FAIL t2_drain%0d got=%0b/%h/%h/%h exp=1/%h/%h/%h", i, dm_we_o, dm_addr_o, dm_wd_o, dm_pc_o, 32'(4*i), 32'hB000_0000 + 32'(i), 32'h200 + 32'(4*i));
      end
      step();
    end
    n_cmp++; if (empty_o !== 1'b1 || dm_we_o !== 1'b0) begin n_err++; $display("FAIL t2_end got=empty %0b we %0b exp=1/0", empty_o, dm_we_o); end
    dm_ready_i = 1'b0;
  endtask

  task automatic test_forward();
    dm_ready_i = 1'b0;
    st_valid_i = 1'b1; st_addr_i = 32'h20; st_wd_i = 32'd1; st_pc_i = 32'h300;
    step();
    st_wd_i = 32'd2; st_pc_i = 32'h304;
    step();
    st_valid_i = 1'b0;
    ld_valid_i = 1'b1; ld_addr_i = 32'h22;
    #1;
    n_cmp++; if (ld_hit_o !== 1'b1 || ld_data_o !== 32'd2) begin n_err++; $display("FAIL t3_youngest got=%0b/%h exp=1/00000002", ld_hit_o, ld_data_o); end
    ld_addr_i = 32'h24;
    #1;
    n_cmp++; if (ld_hit_o !== 1'b0 || ld_data_o !== 32'd0) begin n_err++; $display("FAIL t3_miss got=%0b/%h exp=0/0", ld_hit_o, ld_data_o); end
    ld_valid_i = 1'b0; ld_addr_i = 32'h20;
    #1;
    n_cmp++; if (ld_hit_o !== 1'b0 || ld_data_o !== 32'd0) begin n_err++; $display("FAIL t3_gated got=%0b/%h exp=0/0", ld_hit_o, ld_data_o); end
    dm_ready_i = 1'b1;
    step(); step();
    n_cmp++; if (empty_o !== 1'b1) begin n_err++; $display("FAIL t3_drained got=%0b exp=1", empty_o); end
    dm_ready_i = 1'b0;
  endtask

  task automatic test_drain_forward();
    dm_ready_i = 1'b0;
    st_valid_i = 1'b1; st_addr_i = 32'h30; st_wd_i = 32'd5; st_pc_i = 32'h400;
    step();
    st_valid_i = 1'b0; dm_ready_i = 1'b1; ld_valid_i = 1'b1; ld_addr_i = 32'h30;
    #1;
    n_cmp++; if (dm_we_o !== 1'b1 || ld_hit_o !== 1'b1 || ld_data_o !== 32'd5) begin n_err++; $display("FAIL t4_fire_fwd got=%0b/%0b/%h exp=1/1/00000005", dm_we_o, ld_hit_o, ld_data_o); end
    step();
    n_cmp++; if (ld_hit_o !== 1'b0 || ld_data_o !== 32'd0 || empty_o !== 1'b1) begin n_err++; $display("FAIL t4_after got=%0b/%h/%0b exp=0/0/1", ld_hit_o, ld_data_o, empty_o); end
    n_cmp++; if (dm_addr_o !== 32'h30 || dm_wd_o !== 32'd5) begin n_err++; $display("FAIL t4_hold got=%h/%h exp=00000030/00000005", dm_addr_o, dm_wd_o); end
    // A store pushed this cycle is invisible to a same-cycle load.
    dm_ready_i = 1'b0; st_valid_i = 1'b1; st_addr_i = 32'h60; st_wd_i = 32'h66; ld_addr_i = 32'h60;
    #1;
    n_cmp++; if (ld_hit_o !== 1'b0) begin n_err++; $display("FAIL t4_same_cycle got=%0b exp=0", ld_hit_o); end
    step();
    st_valid_i = 1'b0;
    #1;
    n_cmp++; if (ld_hit_o !== 1'b1 || ld_data_o !== 32'h66) begin n_err++; $display("FAIL t4_next_cycle got=%0b/%h exp=1/00000066", ld_hit_o, ld_data_o); end
    ld_valid_i = 1'b0; dm_ready_i = 1'b1;
    step();
    dm_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    dm_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      st_valid_i = 1'b1; st_addr_i = 32'h70 + 32'(4*i); st_wd_i = 32'h7000 + 32'(i);
      step();
    end
    st_valid_i = 1'b0;
    #1;
    n_cmp++; if (count_o !== 3'd3) begin n_err++; $display("FAIL t5_count got=%0d exp=3", count_o); end
    reset_i = 1'b1; dm_ready_i = 1'b1;
    #1;
    n_cmp++; if (dm_we_o !== 1'b0) begin n_err++; $display("FAIL t5_we_rstcyc got=%0b exp=0", dm_we_o); end
    step();
    reset_i = 1'b0;
    #1;
    n_cmp++; if (count_o !== 3'd0 || empty_o !== 1'b1 || dm_we_o !== 1'b0) begin n_err++; $display("FAIL t5_after got=%0d/%0b/%0b exp=0/1/0", count_o, empty_o, dm_we_o); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (dm_we_o !== 1'b0) begin n_err++; $display("FAIL t5_no_write%0d got=%0b exp=0", i, dm_we_o); end
    end
    dm_ready_i = 1'b0;
  endtask

  task automatic test_coalesce();
    logic [2:0] exp_cnt;
`ifdef SB_COALESCE_EN
    exp_cnt = 3'd1;
`else
    exp_cnt = 3'd2;
`endif
    dm_ready_i = 1'b0;
    st_valid_i = 1'b1; st_addr_i = 32'h40; st_wd_i = 32'd7; st_pc_i = 32'h500;
    step();
    st_wd_i = 32'd9; st_pc_i = 32'h504;
    step();
    st_valid_i = 1'b0; dm_ready_i = 1'b1;
    #1;
    n_cmp++; if (count_o !== exp_cnt) begin n_err++; $display("FAIL t6_count got=%0d exp=%0d", count_o, exp_cnt); end
    if (exp_cnt == 3'd2) begin
      n_cmp++; if (dm_we_o !== 1'b1 || dm_addr_o !== 32'h40 || dm_wd_o !== 32'd7) begin n_err++; $display("FAIL t6_first got=%0b/%h/%h exp=1/00000040/00000007", dm_we_o, dm_addr_o, dm_wd_o); end
      step();
    end
    n_cmp++; if (dm_we_o !== 1'b1 || dm_addr_o !== 32'h40 || dm_wd_o !== 32'd9 || dm_pc_o !== 32'h504) begin n_err++; $display("FAIL t6_last got=%0b/%h/%h/%h exp=1/00000040/00000009/00000504", dm_we_o, dm_addr_o, dm_wd_o, dm_pc_o); end
    step();
    n_cmp++; if (empty_o !== 1'b1 || dm_we_o !== 1'b0) begin n_err++; $display("FAIL t6_end got=%0b/%0b exp=1/0", empty_o, dm_we_o); end
    dm_ready_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    dm_ready_i = 1'b1;
    st_valid_i = 1'b1; st_addr_i = 32'h80; st_wd_i = 32'h800;
    step();
    st_addr_i = 32'h84; st_wd_i = 32'h840;
    #1;
    n_cmp++; if (dm_we_o !== 1'b1 || dm_addr_o !== 32'h80 || st_ready_o !== 1'b1) begin n_err++; $display("FAIL bb_0 got=%0b/%h/%0b exp=1/00000080/1", dm_we_o, dm_addr_o, st_ready_o); end
    step();
    st_addr_i = 32'h88; st_wd_i = 32'h880;
    #1;
    n_cmp++; if (count_o !== 3'd1 || dm_addr_o !== 32'h84 || dm_wd_o !== 32'h840) begin n_err++; $display("FAIL bb_1 got=%0d/%h/%h exp=1/00000084/00000840", count_o, dm_addr_o, dm_wd_o); end
    step();
    st_valid_i = 1'b0;
    #1;
    n_cmp++; if (count_o !== 3'd1 || dm_addr_o !== 32'h88) begin n_err++; $display("FAIL bb_2 got=%0d/%h exp=1/00000088", count_o, dm_addr_o); end
    step();
    n_cmp++; if (empty_o !== 1'b1) begin n_err++; $display("FAIL bb_empty got=%0b exp=1", empty_o); end
    // Same-word store onto a lone head that drains this cycle allocates a new entry.
    st_valid_i = 1'b1; st_addr_i = 32'h90; st_wd_i = 32'd1;
    step();
    st_wd_i = 32'd2;
    #1;
    n_cmp++; if (dm_we_o !== 1'b1 || dm_wd_o !== 32'd1) begin n_err++; $display("FAIL bb_head1 got=%0b/%h exp=1/00000001", dm_we_o, dm_wd_o); end
    step();
    st_valid_i = 1'b0;
    #1;
    n_cmp++; if (count_o !== 3'd1 || dm_we_o !== 1'b1 || dm_addr_o !== 32'h90 || dm_wd_o !== 32'd2) begin n_err++; $display("FAIL bb_head2 got=%0d/%0b/%h/%h exp=1/1/00000090/00000002", count_o, dm_we_o, dm_addr_o, dm_wd_o); end
    step();
    dm_ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_forward();
    test_drain_forward();
    test_reset_mid();
    test_coalesce();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
